// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Initiator side of a byte-wide data memory. Each 16-bit load or store from
// the CPU controller becomes two little-endian byte accesses: the low byte
// goes to A and the high byte to A+1. The memory's read data arrives one
// cycle after the read strobe, and this block absorbs that delay. The
// assembled word comes back together with a one-cycle ack pulse.
//
// Optional build macro: MAU_BYTE_MODE_EN
//   When defined, the block has a 'size' input (0 = byte, 1 = word).
//   A byte access uses only the low-byte cycle. A byte load zero-extends
//   into rdata.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   req           request strobe, sampled only while idle
//   we            1 = store, 0 = load (latched with req)
//   addr          byte address of the low byte (latched with req)
//   wdata         store word (latched with req)
//   size          (MAU_BYTE_MODE_EN only) 0 = byte, 1 = word
//   rdata         load result, held until the next load completes
//   ack           one-cycle completion pulse
//   busy          high whenever not idle
//   memAddr       memory byte address
//   memDataOut    memory write byte
//   memDataIn     memory read byte, registered by the memory on a read strobe
//   memReadEn     memory read strobe
//   memWriteEn    memory write strobe
module mem_access_unit #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [2*DATA_W-1:0]   wdata,
`ifdef MAU_BYTE_MODE_EN
  input  logic                  size,
`endif
  output logic [2*DATA_W-1:0]   rdata,
  output logic                  ack,
  output logic                  busy,
  output logic [ADDR_W-1:0]     memAddr,
  output logic [DATA_W-1:0]     memDataOut,
  input  logic [DATA_W-1:0]     memDataIn,
  output logic                  memReadEn,
  output logic                  memWriteEn
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_LO  = 3'd1,
    WR_HI  = 3'd2,
    RD_LO  = 3'd3,
    RD_HI  = 3'd4,
    RD_CAP = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t                state_reg, state_next;
  logic                  we_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [2*DATA_W-1:0]   wdata_reg;
  logic [2*DATA_W-1:0]   rdata_reg;
  logic                  is_word;
  logic [ADDR_W-1:0]     addr_hi;

`ifdef MAU_BYTE_MODE_EN
  logic size_reg;
  assign is_word = size_reg;
`else
  assign is_word = 1'b1;
`endif

  // The high-byte address wraps modulo 2^ADDR_W.
  assign addr_hi = addr_reg + ADDR_ONE;

  // State, request latches and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
`ifdef MAU_BYTE_MODE_EN
      size_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req) begin
        we_reg    <= we;
        addr_reg  <= addr;
        wdata_reg <= wdata;
`ifdef MAU_BYTE_MODE_EN
        size_reg  <= size;
`endif
      end
      // memDataIn lags the read strobe by one cycle. In RD_HI it therefore
      // holds the low byte, and in RD_CAP it holds the last byte read.
      if (state_reg == RD_HI) begin
        rdata_reg[DATA_W-1:0] <= memDataIn;
      end
      if (state_reg == RD_CAP) begin
        if (is_word) begin
          rdata_reg[2*DATA_W-1:DATA_W] <= memDataIn;
        end else begin
          rdata_reg <= {{DATA_W{1'b0}}, memDataIn};
        end
      end
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_next = state_reg;
    memAddr    = '0;
    memDataOut = '0;
    memReadEn  = 1'b0;
    memWriteEn = 1'b0;
    ack        = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          state_next = we ? WR_LO : RD_LO;
        end
      end
      WR_LO: begin
        memAddr    = addr_reg;
        memDataOut = wdata_reg[DATA_W-1:0];
        memWriteEn = 1'b1;
        state_next = is_word ? WR_HI : DONE;
      end
      WR_HI: begin
        memAddr    = addr_hi;
        memDataOut = wdata_reg[2*DATA_W-1:DATA_W];
        memWriteEn = 1'b1;
        state_next = DONE;
      end
      RD_LO: begin
        memAddr    = addr_reg;
        memReadEn  = 1'b1;
        state_next = is_word ? RD_HI : RD_CAP;
      end
      RD_HI: begin
        memAddr    = addr_hi;
        memReadEn  = 1'b1;
        state_next = RD_CAP;
      end
      RD_CAP: begin
        memAddr    = is_word ? addr_hi : addr_reg;
        state_next = DONE;
      end
      DONE: begin
        ack        = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rdata = rdata_reg;

  // we_reg is latched for completeness; the path is fixed once the state is chosen.
  logic unused_we;
  assign unused_we = we_reg;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the byte-wide data-memory interface (8-bit data, 13-bit byte address, readEn/writeEn strobes).
- Accepts 16-bit word load/store requests from the multi-cycle CPU datapath/controller.
- Sequences each request as two byte accesses (little-endian), absorbs the memory's one-cycle registered read latency, and returns the assembled word with a one-cycle ack.

Parameters:
- ADDR_W, 13, byte address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, memory byte width; the CPU-side word is 2*DATA_W bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  request strobe from the controller, sampled only in IDLE.
- we  in  1  1 = store, 0 = load; latched with req.
- addr  in  ADDR_W  byte address of the low byte; latched with req.
- wdata  in  2*DATA_W  store word; latched with req.
- rdata  out  2*DATA_W  load result; registered; valid while ack=1 and held until the next load completes.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- memAddr  out  ADDR_W  address to memory.
- memDataOut  out  DATA_W  write byte to memory.
- memDataIn  in  DATA_W  memory read byte; updated at the clock edge where memReadEn=1.
- memReadEn  out  1  memory read strobe.
- memWriteEn  out  1  memory write strobe.

Behaviour:
- Reset, asynchronous: state=IDLE; rdata=0; ack=0; busy=0; memReadEn=0; memWriteEn=0; memAddr=0; memDataOut=0; latched addr/wdata/we are cleared.
- Reset mid-operation: outputs drop immediately with no further strobes. A low byte already written is not undone.
- The FSM is Moore. All memory-side outputs are decoded from the state and latched registers only.
- IDLE: if req=1 at the edge, latch we/addr/wdata. Then go to WR_LO if we=1, else RD_LO. req is ignored in every other state.
- WR_LO: memAddr=A, memDataOut=wdata[7:0], memWriteEn=1. Next state is WR_HI.
- WR_HI: memAddr=A+1, memDataOut=wdata[15:8], memWriteEn=1. Next state is DONE.
- RD_LO: memAddr=A, memReadEn=1. Next state is RD_HI.
- RD_HI: memAddr=A+1, memReadEn=1. At the end of this cycle, capture memDataIn (low byte) into rdata[7:0]. Next state is RD_CAP.
- RD_CAP: no strobe; memAddr holds A+1. At the end of this cycle, capture memDataIn into rdata[15:8]. Next state is DONE.
- DONE: ack=1 and busy=1. Next state is IDLE. A req arriving in DONE is not accepted; the controller re-presents it in IDLE.
- memReadEn and memWriteEn are never high in the same cycle.
- Latency from the accepting edge to the ack cycle:
  - store: ack in the 3rd cycle after acceptance.
  - load: ack in the 4th cycle after acceptance.
- Back-to-back requests: minimum spacing is one IDLE cycle between ack and the next acceptance.
- A+1 is computed in ADDR_W bits. A=0x1FFF pairs with 0x0000, with no error.
- rdata changes only during loads. A store does not modify rdata.

Optional Feature:
- Macro MAU_BYTE_MODE_EN.
- Defined:
  - Adds input port size (1 bit, latched with req; 0 = byte, 1 = word).
  - Byte store: WR_LO then DONE; ack in the 2nd cycle after acceptance.
  - Byte load: RD_LO, then RD_CAP capturing memDataIn into rdata[7:0] with rdata[15:8]=0, then DONE; ack in the 3rd cycle.
  - Word accesses are unchanged.
- Not defined: no size port; every access is a word access exactly as above.

Test Plan:
- Reset: assert rst mid-cycle while idle -> all outputs 0 immediately; after release, busy=0 and no strobes for 10 cycles with req=0.
- Word store: req, we=1, addr=0x0100, wdata=0xBEEF -> memWriteEn on 2 consecutive cycles writing 0xEF@0x0100 then 0xBE@0x0101; ack 3rd cycle after acceptance, one cycle wide.
- Word load: then load addr=0x0100 -> memReadEn on 0x0100 then 0x0101; ack 4th cycle; rdata=0xBEEF, held through 5 idle cycles.
- Wrap: store 0x1234 at 0x1FFF, then load -> bytes 0x34@0x1FFF and 0x12@0x0000; rdata=0x1234.
- Busy/abort: hold req=1 with a changing addr during a load -> only the first request is served, the second is accepted after IDLE. Assert rst in WR_HI of a store to 0x0200 -> strobes drop immediately; mem[0x0200] written, mem[0x0201] unchanged.
- With MAU_BYTE_MODE_EN: byte store 0x5A at 0x0010 -> single write, ack 2nd cycle. Byte load 0x0010 -> rdata=0x005A, ack 3rd cycle.
